inst_encoder: RTL
=================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of imm input; only 32 supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  field bundle valid.
REQ-005 in_ready  output  1  encoder can accept a bundle.
REQ-006 opcode  input  7  RV32I major opcode.
REQ-007 rd / rs1 / rs2  input  5 each  register fields.
REQ-008 funct3  input  3; funct7  input  7  function fields.
REQ-009 imm  input  DATA_WIDTH  signed byte-offset immediate.
REQ-010 out_valid  output  1  encoded word valid.
REQ-011 out_ready  input  1  consumer accepts word.
REQ-012 instruction  output  32  encoded word; out_err  output  1  bundle rejected.
REQ-013 enc_count  output  16; err_count  output  16  saturating statistics.

Function
REQ-014 Accept when in_valid and in_ready are both high at a rising edge; pop when out_valid and out_ready are both high.
REQ-015 Results are held in a 2-entry in-order output FIFO; in_ready SHALL be high iff occupancy < 2, with no combinational path from out_ready.
REQ-016 Latency: a bundle accepted at edge N into an empty FIFO SHALL appear on instruction/out_err after edge N.
REQ-017 Simultaneous accept and pop at occupancy 1 SHALL leave occupancy at 1 with order preserved; at occupancy 2 no accept occurs.
REQ-018 instruction/out_err SHALL hold stable while out_valid is high and out_ready is low.
REQ-019 I-type (0000011, 0010011, 1100111): {imm[11:0], rs1, funct3, rd, opcode}.
REQ-020 Shift (0010011, funct3 001 or 101): {funct7, imm[4:0], rs1, funct3, rd, opcode}.
REQ-021 S-type (0100011): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 B-type (1100011): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 J-type (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-024 R-type (0110011): {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored.
REQ-025 Any other opcode SHALL produce instruction 32'h00000013 with out_err=1 in both configurations.
REQ-026 enc_count increments on every accept; err_count increments on every accept whose result has out_err=1; both saturate at 16'hFFFF.

Reset
REQ-027 On reset assertion, immediately and independent of clk: FIFO flushed, out_valid=0, instruction=0, out_err=0, enc_count=0, err_count=0.
REQ-028 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release.
REQ-029 Bundles in flight when reset asserts SHALL be discarded, not emitted.

Configuration
REQ-030 Macro INST_ENCODER_RANGE_CHECK_EN defined: I/S imm must lie in [-2048, 2047]; shift imm in [0, 31]; B imm in [-4096, 4094] with imm[0]=0; J imm in [-1048576, 1048574] with imm[0]=0. A violation SHALL produce instruction 32'h00000013 and out_err=1.
REQ-031 Macro not defined: no range or alignment check; imm is truncated to the format's bit fields. out_err is set only by REQ-025.

Verification
REQ-032 addi: opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> instruction 0x00500093, out_err=0, one cycle after accept.
REQ-033 sw: opcode 0100011, rs1=1, rs2=2, funct3=010, imm=8 -> 0x0020A423; beq: opcode 1100011, rs1=0, rs2=0, funct3=0, imm=-4 -> 0xFE000EE3.
REQ-034 jal: opcode 1101111, rd=1, imm=2048 -> 0x001000EF; opcode 1110011 -> 0x00000013 with out_err=1 and err_count=1.
REQ-035 addi, rd=1, imm=2048 -> with macro: 0x00000013, out_err=1, err_count=1; without macro: 0x80000093, out_err=0, err_count=0.
REQ-036 Hold out_ready=0 and offer 3 bundles -> in_ready low after the 2nd accept. Raise out_ready -> words emerge in order, third bundle accepted, enc_count=3.
REQ-037 Assert reset with 2 entries queued -> out_valid and counters are 0 immediately; after release no stale word is emitted.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I instruction fields into a 32-bit word.
// Results go through a 2-entry in-order output FIFO with valid/ready on both sides.
// Optional feature: define INST_ENCODER_RANGE_CHECK_EN to reject immediates
// that do not fit the format's range or alignment. Without it, immediates are
// truncated to the format's bit fields.
module inst_encoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [DATA_WIDTH-1:0] imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           instruction,
  output logic                  out_err,
  output logic [15:0]           enc_count,
  output logic [15:0]           err_count
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0] w_word;
  logic        w_err;
  logic        w_push;
  logic        w_pop;
  logic        w_unusedImm;

  logic [32:0] r_mem [2];
  logic        r_wrPtr;
  logic        r_rdPtr;
  logic [1:0]  r_count;
  logic [15:0] r_encCount;
  logic [15:0] r_errCount;

  // The upper immediate bits only matter for the optional range check.
  assign w_unusedImm = ^imm[DATA_WIDTH-1:21];

  // Combinational encoder: pick the format from the opcode and build the word.
  always_comb begin
    w_word = NOP_WORD;
    w_err  = 1'b0;
    unique case (opcode)
      7'b0000011, 7'b1100111: begin
        w_word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        if ($signed(imm) < -2048 || $signed(imm) > 2047) w_err = 1'b1;
`endif
      end
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
          if ($signed(imm) < 0 || $signed(imm) > 31) w_err = 1'b1;
`endif
        end else begin
          w_word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
          if ($signed(imm) < -2048 || $signed(imm) > 2047) w_err = 1'b1;
`endif
        end
      end
      7'b0100011: begin
        w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        if ($signed(imm) < -2048 || $signed(imm) > 2047) w_err = 1'b1;
`endif
      end
      7'b1100011: begin
        w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        if ($signed(imm) < -4096 || $signed(imm) > 4094 || imm[0]) w_err = 1'b1;
`endif
      end
      7'b1101111: begin
        w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef INST_ENCODER_RANGE_CHECK_EN
        if ($signed(imm) < -1048576 || $signed(imm) > 1048574 || imm[0]) w_err = 1'b1;
`endif
      end
      7'b0110011: begin
        w_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
    if (w_err) w_word = NOP_WORD;
  end

  assign in_ready    = ~reset & (r_count != 2'd2);
  assign out_valid   = (r_count != 2'd0);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign instruction = out_valid ? r_mem[r_rdPtr][31:0] : 32'h0;
  assign out_err     = out_valid ? r_mem[r_rdPtr][32] : 1'b0;
  assign enc_count   = r_encCount;
  assign err_count   = r_errCount;

  // FIFO storage, pointers, occupancy and saturating statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wrPtr    <= 1'b0;
      r_rdPtr    <= 1'b0;
      r_count    <= 2'd0;
      r_encCount <= 16'h0;
      r_errCount <= 16'h0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= {w_err, w_word};
        r_wrPtr        <= ~r_wrPtr;
        if (r_encCount != 16'hFFFF) r_encCount <= r_encCount + 16'h1;
        if (w_err && r_errCount != 16'hFFFF) r_errCount <= r_errCount + 16'h1;
      end
      if (w_pop) r_rdPtr <= ~r_rdPtr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
